// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests programs: watches data-memory writes to
// tohost, decodes pass/fail/test number, and enforces a cycle budget.
module riscv_test_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int                MAX_TICKS   = 5000,
  parameter int                CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_valid,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [DATA_W-2:0]   fail_id,
  output logic [CNT_W-1:0]    cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d, cycles_inc;
  logic [DATA_W-2:0] fail_id_q, fail_id_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic              done_q, done_d;
  logic              tohost_hit;

  // Only a full-width store to tohost counts; partial stores are ignored.
  assign tohost_hit = wr_valid && (wr_addr == TOHOST_ADDR) && (&wr_strb);
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    fail_id_d = fail_id_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        cycles_d = '0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        cycles_d = cycles_inc;
        // A verdict write in the last budget cycle takes priority over timeout.
        if (tohost_hit && (wr_data == DATA_W'(1))) begin
          state_d = S_PASS;
          pass_d  = 1'b1;
        end else if (tohost_hit && wr_data[0]) begin
          state_d   = S_FAIL;
          fail_d    = 1'b1;
          fail_id_d = wr_data[DATA_W-1:1];
        end else if (cycles_q == CNT_W'(MAX_TICKS - 1)) begin
          state_d   = S_TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: ;
      default: state_d = S_IDLE;
    endcase
    done_d = pass_d | fail_d | timeout_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cycles_q  <= '0;
      fail_id_q <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      fail_id_q <= fail_id_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;
  assign fail_id = fail_id_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed-vector bench for riscv_test_monitor with a 20-cycle budget.
module tb_riscv_test_monitor;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [30:0] fail_id;
  logic [31:0] cycles;

  int n_cmp;
  int n_bad;

  riscv_test_monitor #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TOHOST_ADDR(32'h0000_1000),
    .MAX_TICKS  (20),
    .CNT_W      (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .done    (done),
    .pass    (pass),
    .fail    (fail),
    .timeout (timeout),
    .fail_id (fail_id),
    .cycles  (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got no_finish exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_strb  = s;
    tick(1);
    wr_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".done"},    32'(done),    32'h0);
    check({tag, ".pass"},    32'(pass),    32'h0);
    check({tag, ".fail"},    32'(fail),    32'h0);
    check({tag, ".timeout"}, 32'(timeout), 32'h0);
    check({tag, ".fail_id"}, 32'(fail_id), 32'h0);
    check({tag, ".cycles"},  cycles,       32'h0);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    en       = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;

    #1;
    check_zero("reset");
    tick(2);
    rst = 1'b1;
    tick(1);

    // Pass after 10 RUN cycles.
    start_run();
    check("run0.cycles", cycles, 32'd0);
    tick(10);
    check("run10.cycles", cycles, 32'd10);
    check("run10.done", 32'(done), 32'h0);
    do_write(32'h1000, 32'h1, 4'hF);
    check("pass.pass", 32'(pass), 32'h1);
    check("pass.done", 32'(done), 32'h1);
    check("pass.cycles", cycles, 32'd11);
    check("pass.fail_id", 32'(fail_id), 32'h0);
    check("pass.fail", 32'(fail), 32'h0);
    tick(3);
    check("pass.frozen", cycles, 32'd11);
    async_reset("rst_after_pass1");

    // Fail with test number 3, later writes ignored.
    start_run();
    do_write(32'h1000, 32'h7, 4'hF);
    check("fail.fail", 32'(fail), 32'h1);
    check("fail.fail_id", 32'(fail_id), 32'h3);
    check("fail.pass", 32'(pass), 32'h0);
    check("fail.cycles", cycles, 32'd1);
    do_write(32'h1000, 32'h1, 4'hF);
    check("fail_late.pass", 32'(pass), 32'h0);
    check("fail_late.fail_id", 32'(fail_id), 32'h3);
    check("fail_late.cycles", cycles, 32'd1);
    async_reset("rst_after_fail");

    // Ignored writes in RUN, then timeout.
    start_run();
    do_write(32'h1004, 32'h1, 4'hF);
    check("ign_addr.done", 32'(done), 32'h0);
    do_write(32'h1000, 32'h2, 4'hF);
    check("ign_even.done", 32'(done), 32'h0);
    do_write(32'h1000, 32'h1, 4'h3);
    check("ign_strb.done", 32'(done), 32'h0);
    do_write(32'h1000, 32'h0, 4'hF);
    check("ign_zero.done", 32'(done), 32'h0);
    wr_addr = 32'h1000; wr_data = 32'h1; wr_strb = 4'hF;
    tick(1);
    check("ign_novalid.done", 32'(done), 32'h0);
    check("ign.cycles", cycles, 32'd5);
    tick(14);
    check("pre_to.cycles", cycles, 32'd19);
    check("pre_to.timeout", 32'(timeout), 32'h0);
    tick(1);
    check("to.timeout", 32'(timeout), 32'h1);
    check("to.done", 32'(done), 32'h1);
    check("to.pass", 32'(pass), 32'h0);
    check("to.cycles", cycles, 32'd20);
    tick(3);
    check("to.frozen", cycles, 32'd20);
    async_reset("rst_after_to");

    // Writes in IDLE are ignored.
    do_write(32'h1000, 32'h1, 4'hF);
    do_write(32'h1000, 32'h7, 4'hF);
    check("idle.done", 32'(done), 32'h0);
    check("idle.cycles", cycles, 32'd0);

    // Pass written in the final budget cycle beats timeout.
    start_run();
    tick(19);
    check("last.cycles", cycles, 32'd19);
    do_write(32'h1000, 32'h1, 4'hF);
    check("last.pass", 32'(pass), 32'h1);
    check("last.timeout", 32'(timeout), 32'h0);
    check("last.cycles", cycles, 32'd20);
    async_reset("rst_after_last");

    // Reset mid-run at cycle 7, then restart from zero.
    start_run();
    tick(7);
    check("mid.cycles", cycles, 32'd7);
    async_reset("rst_mid_run");
    start_run();
    check("restart0.cycles", cycles, 32'd0);
    tick(1);
    check("restart1.cycles", cycles, 32'd1);
    do_write(32'h1000, 32'h1, 4'hF);
    check("restart.pass", 32'(pass), 32'h1);
    async_reset("rst_after_pass2");

    // New run after reset fails with test number 2.
    start_run();
    tick(2);
    do_write(32'h1000, 32'h5, 4'hF);
    check("fail2.fail", 32'(fail), 32'h1);
    check("fail2.fail_id", 32'(fail_id), 32'h2);
    check("fail2.cycles", cycles, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
